ps2_key_sequencer: RTL and testbench

Sequencing controller between the PS/2 byte receiver and the key-display/counter datapath. Consumes raw scan-code bytes over a valid/ready handshake, decodes make, break (F0) and extended (E0) sequences, and tracks Shift/Ctrl modifier state. Emits one complete key event per non-modifier key transition into a small event FIFO, and maintains a key-press counter, so downstream display logic never parses protocol bytes itself.

---
 rtl/kbseq_pkg.sv | 31 +++
 rtl/kbseq_fifo.sv | 52 +++++
 rtl/ps2_key_sequencer.sv | 125 ++++++++++++
 tb/tb_ps2_key_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbseq_pkg.sv
// Shared types and scan-code constants for the PS/2 key sequencer.
package kbseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } kbseq_state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       shift;
        logic       ctrl;
    } kbseq_event_t;

endpackage

// File: rtl/kbseq_fifo.sv
// Synchronous event FIFO; full/empty derive from a registered occupancy count.
module kbseq_fifo
    import kbseq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  kbseq_event_t push_data,
    input  logic         pop,
    output kbseq_event_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    kbseq_event_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code parser: prefix FSM, modifier tracking, event FIFO and press counter.
// Define KBSEQ_REPEAT_FILTER_EN to drop typematic repeats of the held key.
module ps2_key_sequencer
    import kbseq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             ev_shift,
    output logic             ev_ctrl,
    output logic [CNT_W-1:0] press_cnt,
    output logic             proto_err
);

    kbseq_state_t state, nxt_state;
    logic         shift_q, ctrl_q;
    logic         accept, is_key, key_ext, key_brk, bad;
    logic         is_shift, is_ctrl, is_repeat, ev_push;
    logic         fifo_full, fifo_empty;
    kbseq_event_t push_data, head;

`ifdef KBSEQ_REPEAT_FILTER_EN
    logic [8:0] held_q;
    // Code 00 is never a valid key, so {00,0} doubles as "nothing held".
    assign is_repeat = !key_brk && ({rx_data, key_ext} == held_q);
`else
    assign is_repeat = 1'b0;
`endif

    assign accept = rx_valid && rx_ready;

    always_comb begin
        nxt_state = state;
        is_key    = 1'b0;
        key_ext   = 1'b0;
        key_brk   = 1'b0;
        bad       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_data == SC_EXT)                               nxt_state = ST_EXT;
                else if (rx_data == SC_BRK)                          nxt_state = ST_BRK;
                else if (rx_data == SC_ERR0 || rx_data == SC_ERR1)   bad = 1'b1;
                else if (!(rx_data == SC_ACK || rx_data == SC_BAT_OK ||
                           rx_data == SC_ECHO || rx_data == SC_RESEND)) is_key = 1'b1;
            end
            ST_EXT: begin
                nxt_state = ST_IDLE;
                if (rx_data == SC_BRK) nxt_state = ST_EXT_BRK;
                else if (rx_data == SC_EXT || rx_data == SC_ERR0 || rx_data == SC_ERR1) bad = 1'b1;
                else begin
                    is_key  = 1'b1;
                    key_ext = 1'b1;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                if (rx_data == SC_EXT || rx_data == SC_BRK ||
                    rx_data == SC_ERR0 || rx_data == SC_ERR1) bad = 1'b1;
                else begin
                    is_key  = 1'b1;
                    key_brk = 1'b1;
                    key_ext = (state == ST_EXT_BRK);
                end
            end
        endcase
    end

    assign is_shift  = !key_ext && (rx_data == SC_LSHIFT || rx_data == SC_RSHIFT);
    assign is_ctrl   = (rx_data == SC_CTRL);
    assign ev_push   = accept && is_key && !is_shift && !is_ctrl && !is_repeat;
    assign push_data = '{code: rx_data, ext: key_ext, brk: key_brk, shift: shift_q, ctrl: ctrl_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shift_q   <= 1'b0;
            ctrl_q    <= 1'b0;
            press_cnt <= '0;
            proto_err <= 1'b0;
`ifdef KBSEQ_REPEAT_FILTER_EN
            held_q    <= '0;
`endif
        end else if (accept) begin
            state <= nxt_state;
            if (bad) proto_err <= 1'b1;
            if (is_key && is_shift) shift_q <= !key_brk;
            if (is_key && is_ctrl)  ctrl_q  <= !key_brk;
            if (ev_push && !key_brk) press_cnt <= press_cnt + 1'b1;
`ifdef KBSEQ_REPEAT_FILTER_EN
            if (ev_push && !key_brk) held_q <= {rx_data, key_ext};
            else if (ev_push && key_brk && {rx_data, key_ext} == held_q) held_q <= '0;
`endif
        end
    end

    kbseq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ev_push),
        .push_data (push_data),
        .pop       (ev_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_ready = !fifo_full;
    assign ev_valid = !fifo_empty;
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_break = head.brk;
    assign ev_shift = head.shift;
    assign ev_ctrl  = head.ctrl;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench: directed table, hand sequences, and random traffic vs a queue model.
module tb_ps2_key_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          ev_valid;
    logic          ev_ready;
    logic [7:0]    ev_code;
    logic          ev_ext, ev_break, ev_shift, ev_ctrl;
    logic [CW-1:0] press_cnt;
    logic          proto_err;

    int n_pass  = 0;
    int n_total = 0;

    ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .ev_shift  (ev_shift),
        .ev_ctrl   (ev_ctrl),
        .press_cnt (press_cnt),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [11:0]   exp_q[$];
    logic          m_e0, m_f0, m_shift, m_ctrl, m_err, m_held_v;
    logic [8:0]    m_held;
    logic [CW-1:0] m_cnt;

    function automatic bit filter_on();
`ifdef KBSEQ_REPEAT_FILTER_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_e0 = 0; m_f0 = 0; m_shift = 0; m_ctrl = 0; m_err = 0;
        m_held_v = 0; m_held = '0; m_cnt = '0;
    endtask

    task automatic model_key(input logic [7:0] c, input logic ext, input logic brk);
        m_e0 = 0; m_f0 = 0;
        if (!ext && (c == 8'h12 || c == 8'h59)) m_shift = !brk;
        else if (c == 8'h14) m_ctrl = !brk;
        else if (!brk) begin
            if (!(filter_on() && m_held_v && m_held == {c, ext})) begin
                exp_q.push_back({c, ext, 1'b0, m_shift, m_ctrl});
                m_cnt++;
                m_held_v = 1; m_held = {c, ext};
            end
        end else begin
            exp_q.push_back({c, ext, 1'b1, m_shift, m_ctrl});
            if (m_held_v && m_held == {c, ext}) m_held_v = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h00 || b == 8'hFF) begin
            m_err = 1; m_e0 = 0; m_f0 = 0;
        end else if (!m_e0 && !m_f0) begin
            if (b == 8'hE0) m_e0 = 1;
            else if (b == 8'hF0) m_f0 = 1;
            else if (!(b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE)) model_key(b, 0, 0);
        end else if (!m_f0) begin
            if (b == 8'hF0) m_f0 = 1;
            else if (b == 8'hE0) begin m_err = 1; m_e0 = 0; end
            else model_key(b, 1, 0);
        end else begin
            if (b == 8'hE0 || b == 8'hF0) begin m_err = 1; m_e0 = 0; m_f0 = 0; end
            else model_key(b, m_e0, 1);
        end
    endtask

    // Monitor: compares the pending cycle's outputs, then applies its pop and push.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            check("rx_ready_occ", rx_ready, exp_q.size() < DEPTH);
            check("ev_valid_occ", ev_valid, exp_q.size() != 0);
            check("press_cnt_model", press_cnt, m_cnt);
            check("proto_err_model", proto_err, m_err);
            if (ev_valid && ev_ready && exp_q.size() != 0)
                check("ev_head", {ev_code, ev_ext, ev_break, ev_shift, ev_ctrl}, exp_q.pop_front());
            if (rx_valid && rx_ready) model_byte(rx_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rx_valid = 0;
        rst = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1;
        #1;
        while (!rx_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!rx_ready) check("send_timeout", rx_ready, 1);
        else @(negedge clk);
        rx_valid = 0;
    endtask

    typedef struct {
        logic [7:0]    data;
        logic          vld;
        logic [7:0]    code;
        logic          ext, brk, shift, ctrl;
        logic [CW-1:0] cnt;
        logic          err;
    } step_t;

    function automatic step_t mk(logic [7:0] d, logic v, logic [7:0] c, logic e, logic b,
                                 logic s, logic k, logic [CW-1:0] n, logic r);
        step_t t;
        t.data = d; t.vld = v; t.code = c; t.ext = e; t.brk = b;
        t.shift = s; t.ctrl = k; t.cnt = n; t.err = r;
        return t;
    endfunction

    step_t       tbl[$];
    logic [7:0]  pool[12];

    initial begin
        logic last_acc;
        rst = 0; rx_valid = 0; rx_data = '0; ev_ready = 0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check("rst_rx_ready", rx_ready, 1);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_press_cnt", press_cnt, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_ev_fields", {ev_code, ev_ext, ev_break, ev_shift, ev_ctrl}, 0);
        @(negedge clk);
        rst = 1;

        // Directed table: one byte per step, event expected right after the accepting edge.
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(8'h12, 0, 8'h00, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 1, 0, 2, 0));
        tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 1, 1, 0, 2, 0));
        tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(8'h12, 0, 8'h00, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(8'h75, 1, 8'h75, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(8'h75, 1, 8'h75, 1, 1, 0, 0, 3, 0));
        tbl.push_back(mk(8'h14, 0, 8'h00, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(8'h24, 1, 8'h24, 0, 0, 0, 1, 4, 0));
        tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(8'h14, 0, 8'h00, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(8'hFA, 0, 8'h00, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 4, 1));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 0, 0, 5, 1));

        ev_ready = 1;
        @(negedge clk);
        foreach (tbl[i]) begin
            rx_data  = tbl[i].data;
            rx_valid = 1;
            @(negedge clk);
            rx_valid = 0;
            #1;
            check($sformatf("tbl%0d_ev_valid", i), ev_valid, tbl[i].vld);
            if (tbl[i].vld)
                check($sformatf("tbl%0d_event", i), {ev_code, ev_ext, ev_break, ev_shift, ev_ctrl},
                      {tbl[i].code, tbl[i].ext, tbl[i].brk, tbl[i].shift, tbl[i].ctrl});
            check($sformatf("tbl%0d_press_cnt", i), press_cnt, tbl[i].cnt);
            check($sformatf("tbl%0d_proto_err", i), proto_err, tbl[i].err);
            @(negedge clk);
        end

        // Back-pressure: four makes fill the FIFO, the fifth waits.
        do_reset();
        ev_ready = 0;
        send_byte(8'h1D); send_byte(8'h1E); send_byte(8'h1F); send_byte(8'h20);
        #1;
        check("bp_rx_ready_low", rx_ready, 0);
        check("bp_head", ev_code, 8'h1D);
        rx_data = 8'h21; rx_valid = 1;
        repeat (3) @(negedge clk);
        #1;
        check("bp_still_full", rx_ready, 0);
        check("bp_head_stable", {ev_code, ev_ext, ev_break}, {8'h1D, 2'b00});
        check("bp_cnt_held", press_cnt, 4);
        @(negedge clk);
        ev_ready = 1;
        @(negedge clk);
        #1;
        check("bp_rx_ready_rise", rx_ready, 1);
        @(negedge clk);
        rx_valid = 0;
        repeat (6) @(negedge clk);
        #1;
        check("bp_drained", ev_valid, 0);
        check("bp_cnt_final", press_cnt, 5);

        // Reset mid-sequence drops the E0 prefix.
        do_reset();
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h75);
        #1;
        check("rst_mid_code", {ev_valid, ev_code, ev_ext}, {1'b1, 8'h75, 1'b0});

        // Repeated makes.
        @(negedge clk);
        do_reset();
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        repeat (4) @(negedge clk);
        check("repeat_cnt", press_cnt, filter_on() ? 1 : 3);

        // Counter wrap: 256 press/release pairs.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        end
        repeat (4) @(negedge clk);
        check("wrap_cnt", press_cnt, 0);

        // Random traffic with random back-pressure.
        do_reset();
        pool = '{8'h1C, 8'h1D, 8'h75, 8'h12, 8'h59, 8'h14, 8'hE0, 8'hF0, 8'hF0, 8'hFA, 8'h24, 8'h1C};
        last_acc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!rx_valid || last_acc) begin
                rx_valid = ($urandom_range(0, 3) != 0);
                rx_data  = ($urandom_range(0, 199) == 0) ? 8'h00 : pool[$urandom_range(0, 11)];
            end
            ev_ready = ($urandom_range(0, 2) != 0);
            #1;
            last_acc = rx_valid && rx_ready;
        end
        @(negedge clk);
        rx_valid = 0;
        ev_ready = 1;
        repeat (8) @(negedge clk);
        #3;
        check("rand_drained", ev_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
